load_fsm_nch: RTL and testbench
===============================

Name: load_fsm_nch

Overview:
- Parametrised successor of the scratchpad load sequencer.
- Pops load instructions from the instruction FIFO and issues one scratchpad row read per matrix row.
- Routes each returned row into one of N_CH weight FIFOs or N_CH input FIFOs.
- Adds over the previous generation: multi-row burst instructions, generic channel count, an address stride, full-FIFO back-pressure per row, and an illegal-opcode discard path with error pulse.

Parameters:
- N_CH, 4, number of weight/input FIFO channel pairs (power of 2, ≥2); CH_W = $clog2(N_CH) is derived.
- ROW_BITS, 64, bits per scratchpad row.
- ROW_W, 2, row-index width; a burst is 1..2^ROW_W rows.
- ADDR_W, 32, scratchpad address width.
- ROW_STRIDE, 8, address increment between consecutive rows.
- INSTR_W, 2+CH_W+ROW_W+ADDR_W, derived instruction width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- instr_empty  in  1  instruction FIFO empty.
- instr_rdata  in  INSTR_W  head entry {op[1:0], ch[CH_W-1:0], rows_m1[ROW_W-1:0], addr[ADDR_W-1:0]}.
- instr_ren  out  1  pop instruction FIFO.
- sload  out  1  scratchpad read request.
- load_addr  out  ADDR_W  request address.
- sload_hit  in  1  read data valid this cycle.
- load_data  in  ROW_BITS  read data.
- w_full  in  N_CH  per-channel weight FIFO full.
- w_wen  out  N_CH  one-hot weight FIFO write enable.
- w_wdata  out  ROW_W+ROW_BITS  {row_idx, row data}, shared by all channels.
- r_full  in  N_CH  per-channel input FIFO full.
- r_wen  out  N_CH  one-hot input FIFO write enable.
- r_wdata  out  ROW_W+ROW_BITS  {row_idx, row data}, shared by all channels.
- new_weight  out  1  one-cycle pulse with the first weight row write of a burst.
- busy  out  1  state != IDLE.
- err_op  out  1  one-cycle pulse when an illegal opcode is discarded.

Behaviour:
- Opcodes: 2'b00 = load weights, 2'b01 = load inputs, 2'b1x = illegal.
- Reset (async, nRST low): state = IDLE; all outputs 0; internal op, ch, row counter, address and data registers 0. Reset asserted mid-burst abandons the burst with no further writes; the FIFO entry already popped is lost.
- IDLE:
  - If !instr_empty: instr_ren = 1 for exactly one cycle, instr_rdata is latched, and the next state is REQ.
  - If the latched op is illegal, the next state is IDLE instead and err_op pulses in the following cycle.
  - instr_ren is never asserted while instr_empty = 1.
- REQ:
  - sload = 1 and load_addr = base + row_idx*ROW_STRIDE (truncated mod 2^ADDR_W).
  - Held steady until sload_hit. The hit cycle captures load_data into the row register; next state is PUSH.
- PUSH:
  - Target full bit = w_full[ch] (op 00) or r_full[ch] (op 01).
  - While full: stall with all wen = 0 and sload = 0.
  - When not full: assert exactly one wen bit (one-hot at ch) for one cycle, with wdata = {row_idx, captured row}. new_weight = 1 in this cycle iff op = 00 and row_idx = 0.
  - Then: if row_idx == rows_m1, go to IDLE; else increment row_idx and go to REQ.
- Timing: minimum 1 + 2 cycles per row (fetch + REQ/PUSH with immediate hit, not full). A new instruction fetch occurs the cycle after the last PUSH.
- Address wrap: no carry beyond ADDR_W.
- Row index: row_idx never wraps within a burst; rows_m1 = 2^ROW_W - 1 gives the maximum burst.
- Both *_wdata outputs are registered and hold their value between writes. At most one of w_wen|r_wen is nonzero in any cycle.
- A full flag toggling during PUSH is sampled each cycle; a write happens only in a cycle where it is 0.

Test Plan:
- Single-row weight load: op 00, ch 2, rows_m1 0, addr 0x100, hit 1 cycle later.
  - Required: load_addr = 0x100, w_wen = 4'b0100 once, w_wdata = {0, data}, new_weight pulses once, busy back to 0, no r_wen.
- 4-row input burst: op 01, ch 3, rows_m1 3, addr 0x40, ROW_STRIDE 8.
  - Required: addresses 0x40, 0x48, 0x50, 0x58; r_wen = 4'b1000 four times with row_idx 0..3; new_weight stays 0.
- Back-pressure: w_full[1] = 1 for 5 cycles during PUSH of ch 1.
  - Required: no wen for 5 cycles, then exactly one write with the unchanged captured data; sload = 0 throughout the stall.
- Delayed hit and illegal opcode:
  - sload_hit delayed 3 cycles → sload and load_addr held constant for those cycles.
  - Instruction op 2'b10 → instr_ren once, err_op pulses once, no sload/wen, next instruction processed normally.
- Address wrap and back-to-back instructions: addr 0xFFFFFFF8, rows_m1 1 → second address 0x00000000. Two queued instructions → second instr_ren issued the cycle after the first burst's last PUSH.
- Reset mid-burst: nRST low during REQ of row 2.
  - Required: all outputs 0 immediately (async).
  - After release: IDLE, no residual wen; the next instruction starts at row_idx 0.

Source files
------------

// File: rtl/load_fsm_nch.sv
// Scratchpad load sequencer: pops load instructions, fetches one scratchpad row per
// matrix row and routes each row into one of N_CH weight or input FIFOs.
//
// state | meaning
// IDLE  | waiting for an instruction; pops and latches the FIFO head when one is present
// REQ   | scratchpad read request for the current row, held until sload_hit
// PUSH  | captured row waits for its target FIFO to be non-full, then is written once
module load_fsm_nch #(
    parameter int N_CH       = 4,
    parameter int ROW_BITS   = 64,
    parameter int ROW_W      = 2,
    parameter int ADDR_W     = 32,
    parameter int ROW_STRIDE = 8,
    localparam int CH_W      = $clog2(N_CH),
    localparam int INSTR_W   = 2 + CH_W + ROW_W + ADDR_W
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      instr_empty,
    input  logic [INSTR_W-1:0]        instr_rdata,
    output logic                      instr_ren,
    output logic                      sload,
    output logic [ADDR_W-1:0]         load_addr,
    input  logic                      sload_hit,
    input  logic [ROW_BITS-1:0]       load_data,
    input  logic [N_CH-1:0]           w_full,
    output logic [N_CH-1:0]           w_wen,
    output logic [ROW_W+ROW_BITS-1:0] w_wdata,
    input  logic [N_CH-1:0]           r_full,
    output logic [N_CH-1:0]           r_wen,
    output logic [ROW_W+ROW_BITS-1:0] r_wdata,
    output logic                      new_weight,
    output logic                      busy,
    output logic                      err_op
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        PUSH = 2'd2
    } stateE;

    stateE                     state;
    stateE                     stateNext;
    logic                      armed;
    logic [1:0]                opReg;
    logic [CH_W-1:0]           chReg;
    logic [ROW_W-1:0]          rowsM1Reg;
    logic [ROW_W-1:0]          rowIdx;
    logic [ADDR_W-1:0]         curAddr;
    logic [ROW_W+ROW_BITS-1:0] wDataReg;
    logic [ROW_W+ROW_BITS-1:0] rDataReg;
    logic                      errOpReg;

    logic [1:0]                instrOp;
    logic [CH_W-1:0]           instrCh;
    logic [ROW_W-1:0]          instrRowsM1;
    logic [ADDR_W-1:0]         instrAddr;
    logic                      fetch;
    logic                      isWeight;
    logic                      targetFull;
    logic                      rowWrite;
    logic                      lastRow;
    logic [N_CH-1:0]           chOneHot;

    assign instrOp     = instr_rdata[INSTR_W-1 -: 2];
    assign instrCh     = instr_rdata[ADDR_W+ROW_W +: CH_W];
    assign instrRowsM1 = instr_rdata[ADDR_W +: ROW_W];
    assign instrAddr   = instr_rdata[ADDR_W-1:0];

    // armed is cleared asynchronously so the combinational pop is 0 while in reset
    assign fetch      = (state == IDLE) && !instr_empty && armed;
    assign isWeight   = (opReg == 2'b00);
    assign targetFull = isWeight ? w_full[chReg] : r_full[chReg];
    assign rowWrite   = (state == PUSH) && !targetFull;
    assign lastRow    = (rowIdx == rowsM1Reg);
    assign chOneHot   = N_CH'(1) << chReg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        w_wen      = '0;
        r_wen      = '0;
        new_weight = 1'b0;
        case (state)
            IDLE: begin
                if (fetch) begin
                    stateNext = instrOp[1] ? IDLE : REQ;
                end
            end
            REQ: begin
                if (sload_hit) begin
                    stateNext = PUSH;
                end
            end
            PUSH: begin
                if (rowWrite) begin
                    if (isWeight) begin
                        w_wen      = chOneHot;
                        new_weight = (rowIdx == '0);
                    end else begin
                        r_wen = chOneHot;
                    end
                    stateNext = lastRow ? IDLE : REQ;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            armed     <= 1'b0;
            opReg     <= '0;
            chReg     <= '0;
            rowsM1Reg <= '0;
            rowIdx    <= '0;
            curAddr   <= '0;
            wDataReg  <= '0;
            rDataReg  <= '0;
            errOpReg  <= 1'b0;
        end else begin
            armed    <= 1'b1;
            errOpReg <= fetch && instrOp[1];
            if (fetch) begin
                opReg     <= instrOp;
                chReg     <= instrCh;
                rowsM1Reg <= instrRowsM1;
                rowIdx    <= '0;
                curAddr   <= instrAddr;
            end
            // each data register only changes for its own op, so it holds between writes
            if ((state == REQ) && sload_hit) begin
                if (isWeight) begin
                    wDataReg <= {rowIdx, load_data};
                end else begin
                    rDataReg <= {rowIdx, load_data};
                end
            end
            if (rowWrite && !lastRow) begin
                rowIdx  <= rowIdx + ROW_W'(1);
                curAddr <= curAddr + ADDR_W'(ROW_STRIDE);
            end
        end
    end

    assign instr_ren = fetch;
    assign sload     = (state == REQ);
    assign load_addr = curAddr;
    assign w_wdata   = wDataReg;
    assign r_wdata   = rDataReg;
    assign busy      = (state != IDLE);
    assign err_op    = errOpReg;

endmodule

// File: tb/tb_load_fsm_nch.sv
// Bench for load_fsm_nch: directed scenarios plus a randomized phase, checked against a
// row-level model of expected reads and FIFO writes derived from each popped instruction.
module tb_load_fsm_nch;
    localparam int N_CH = 4, CH_W = 2, ROW_BITS = 64, ROW_W = 2, ADDR_W = 32, ROW_STRIDE = 8;
    localparam int INSTR_W = 2 + CH_W + ROW_W + ADDR_W;

    logic                      CLK = 1'b0;
    logic                      nRST = 1'b0;
    logic                      instr_empty;
    logic [INSTR_W-1:0]        instr_rdata;
    logic                      instr_ren;
    logic                      sload;
    logic [ADDR_W-1:0]         load_addr;
    logic                      sload_hit;
    logic [ROW_BITS-1:0]       load_data;
    logic [N_CH-1:0]           w_full, w_wen, r_full, r_wen;
    logic [ROW_W+ROW_BITS-1:0] w_wdata, r_wdata;
    logic                      new_weight, busy, err_op;

    always #5 CLK = ~CLK;

    load_fsm_nch dut (
        .CLK(CLK), .nRST(nRST), .instr_empty(instr_empty), .instr_rdata(instr_rdata),
        .instr_ren(instr_ren), .sload(sload), .load_addr(load_addr), .sload_hit(sload_hit),
        .load_data(load_data), .w_full(w_full), .w_wen(w_wen), .w_wdata(w_wdata),
        .r_full(r_full), .r_wen(r_wen), .r_wdata(r_wdata), .new_weight(new_weight),
        .busy(busy), .err_op(err_op)
    );

    typedef struct {
        logic [1:0]          op;
        logic [CH_W-1:0]     ch;
        int                  row;
        logic [ADDR_W-1:0]   addr;
        logic [ROW_BITS-1:0] data;
        bit                  captured;
        bit                  last;
        int                  hitWait;
        int                  stallCyc;
    } rowT;

    rowT                expQ[$];
    logic [INSTR_W-1:0] instrQ[$];
    int  checks = 0, failures = 0, cycleCnt = 0;
    int  nWrites, nNewW, nErr, nStall, nHitWait, lastFinal, gapCheck;
    int  hitMode = 0, stallMode = 0;
    bit  randomFull = 0, errNext = 0, sawZero = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic enqueue(input logic [1:0] op, input int ch, input int rm1, input logic [ADDR_W-1:0] a);
        instrQ.push_back({op, CH_W'(ch), ROW_W'(rm1), a});
    endtask

    task automatic clearCounters();
        nWrites = 0; nNewW = 0; nErr = 0; nStall = 0; nHitWait = 0;
    endtask

    task automatic cycle();
        rowT h;
        logic [N_CH-1:0] oh;
        @(posedge CLK); #1;
        cycleCnt++;
        instr_empty = (instrQ.size() == 0);
        instr_rdata = instr_empty ? '0 : instrQ[0];
        sload_hit   = 1'b0;
        load_data   = {$urandom, $urandom};
        w_full      = randomFull ? N_CH'($urandom) : '0;
        r_full      = randomFull ? N_CH'($urandom) : '0;
        if (expQ.size() > 0) begin
            h = expQ[0];
            if (!h.captured && sload) begin
                if (h.hitWait > 0) begin h.hitWait--; nHitWait++; end
                else sload_hit = 1'b1;
            end
            if (h.captured && h.stallCyc > 0) begin
                if (h.op == 2'b00) w_full[h.ch] = 1'b1; else r_full[h.ch] = 1'b1;
                h.stallCyc--;
            end
            expQ[0] = h;
        end
        #1;
        chk("err_op", err_op, errNext);
        errNext = 0;
        if (instr_empty) chk("ren_when_empty", instr_ren, 0);
        chk("wen_exclusive", (|w_wen) && (|r_wen), 0);
        if (sload && load_addr == '0) sawZero = 1;
        if (sload && expQ.size() == 0) chk("sload_unexpected", 1, 0);
        if (expQ.size() > 0) begin
            if (expQ[0].captured) chk("sload_in_push", sload, 0);
            else if (sload) chk("load_addr", load_addr, expQ[0].addr);
        end
        if ((|w_wen) || (|r_wen)) begin
            if (expQ.size() == 0 || !expQ[0].captured) chk("write_unexpected", 1, 0);
            else begin
                h  = expQ.pop_front();
                oh = N_CH'(1) << h.ch;
                chk("w_wen", w_wen, (h.op == 2'b00) ? oh : '0);
                chk("r_wen", r_wen, (h.op == 2'b01) ? oh : '0);
                if (h.op == 2'b00) chk("w_wdata", w_wdata, {ROW_W'(h.row), h.data});
                else               chk("r_wdata", r_wdata, {ROW_W'(h.row), h.data});
                chk("new_weight", new_weight, (h.op == 2'b00) && (h.row == 0));
                chk("write_while_full", (h.op == 2'b00) ? w_full[h.ch] : r_full[h.ch], 0);
                nWrites++;
                if (new_weight) nNewW++;
                if (h.last) lastFinal = cycleCnt;
            end
        end else begin
            chk("new_weight_idle", new_weight, 0);
            if (expQ.size() > 0 && expQ[0].captured) nStall++;
        end
        if (sload && sload_hit && expQ.size() > 0 && !expQ[0].captured) begin
            h = expQ[0]; h.captured = 1; h.data = load_data; expQ[0] = h;
        end
        if (instr_ren && instrQ.size() > 0) begin
            logic [INSTR_W-1:0] ins;
            logic [1:0] op;
            int rm1;
            ins = instrQ.pop_front();
            if (gapCheck == 1) begin chk("b2b_gap", cycleCnt - lastFinal, 1); gapCheck = 0; end
            else if (gapCheck == 2) gapCheck = 1;
            op  = ins[INSTR_W-1 -: 2];
            rm1 = int'(ins[ADDR_W +: ROW_W]);
            if (op[1]) begin errNext = 1; nErr++; end
            else for (int r = 0; r <= rm1; r++) begin
                h.op = op; h.ch = ins[ADDR_W+ROW_W +: CH_W]; h.row = r;
                h.addr = ins[ADDR_W-1:0] + ADDR_W'(r * ROW_STRIDE);
                h.data = '0; h.captured = 0; h.last = (r == rm1);
                h.hitWait  = (hitMode < 0) ? int'($urandom_range(0, 3)) : hitMode;
                h.stallCyc = stallMode;
                expQ.push_back(h);
            end
        end
    endtask

    task automatic runIdle(input int maxCycles);
        bit done;
        done = 0;
        for (int i = 0; i < maxCycles; i++) begin
            if (instrQ.size() == 0 && expQ.size() == 0 && !errNext && !busy) begin done = 1; break; end
            cycle();
        end
        chk("run_timeout", done, 1);
        chk("busy_idle", busy, 0);
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_ren"}, instr_ren, 0);
        chk({tag, "_sload"}, sload, 0);
        chk({tag, "_addr"}, load_addr, 0);
        chk({tag, "_wen"}, {w_wen, r_wen}, 0);
        chk({tag, "_wdata"}, {w_wdata, r_wdata}, 0);
        chk({tag, "_misc"}, {new_weight, busy, err_op}, 0);
    endtask

    initial begin
        bit found;
        clearCounters();
        lastFinal = 0; gapCheck = 0;
        sload_hit = 0; load_data = '0; w_full = '0; r_full = '0;
        // Reset state with a pending instruction: nothing may be popped during reset
        enqueue(2'b00, 2, 0, 32'h100);
        instr_empty = 0; instr_rdata = instrQ[0];
        #3 chkAllZero("reset");
        repeat (2) @(posedge CLK);
        #1 nRST = 1;

        // Single-row weight load
        runIdle(40);
        chk("t1_writes", nWrites, 1);
        chk("t1_new_weight", nNewW, 1);

        // 4-row input burst
        clearCounters();
        enqueue(2'b01, 3, 3, 32'h40);
        runIdle(60);
        chk("t2_writes", nWrites, 4);
        chk("t2_new_weight", nNewW, 0);

        // Back-pressure on weight channel 1
        clearCounters(); stallMode = 5;
        enqueue(2'b00, 1, 0, 32'h80);
        runIdle(60);
        stallMode = 0;
        chk("t3_stall_cycles", nStall, 5);
        chk("t3_writes", nWrites, 1);

        // Delayed hit
        clearCounters(); hitMode = 3;
        enqueue(2'b01, 0, 0, 32'h300);
        runIdle(60);
        hitMode = 0;
        chk("t4_hit_wait", nHitWait, 3);
        chk("t4_writes", nWrites, 1);

        // Illegal opcode followed by a normal instruction
        clearCounters();
        enqueue(2'b10, 1, 1, 32'h500);
        enqueue(2'b00, 0, 1, 32'h600);
        runIdle(60);
        chk("t5_err", nErr, 1);
        chk("t5_writes", nWrites, 2);
        chk("t5_new_weight", nNewW, 1);

        // Address wrap and back-to-back instructions
        clearCounters(); sawZero = 0; gapCheck = 2;
        enqueue(2'b01, 2, 1, 32'hFFFF_FFF8);
        enqueue(2'b00, 3, 0, 32'h10);
        runIdle(60);
        chk("t6_wrap_zero", sawZero, 1);
        chk("t6_writes", nWrites, 3);
        chk("t6_gap_done", gapCheck, 0);

        // Reset mid-burst during REQ of row 2
        clearCounters();
        enqueue(2'b01, 0, 3, 32'h200);
        found = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (sload && expQ.size() > 0 && expQ[0].row == 2) begin found = 1; break; end
        end
        chk("t7_reached_row2", found, 1);
        #1 nRST = 0;
        #1 chkAllZero("midreset");
        expQ.delete(); errNext = 0;
        enqueue(2'b00, 1, 0, 32'h700);
        instr_empty = 0; instr_rdata = instrQ[0];
        repeat (2) begin
            @(posedge CLK); #2;
            chk("reset_hold_ren", instr_ren, 0);
            chk("reset_hold_busy", busy, 0);
        end
        nRST = 1;
        clearCounters();
        runIdle(40);
        chk("t7_writes", nWrites, 1);
        chk("t7_new_weight", nNewW, 1);

        // Randomized instructions, hit delays and toggling full flags
        clearCounters(); randomFull = 1; hitMode = -1;
        for (int i = 0; i < 30; i++) begin
            logic [1:0] op;
            op = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            enqueue(op, int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 3)), $urandom);
        end
        runIdle(6000);
        randomFull = 0; hitMode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
